// File: rtl/uart_pkg.sv
// Shared UART definitions: transmitter state encoding, default bit timing
// and a parity helper used by both ends of the link.
package uart_pkg;

  // 50 MHz system clock, 115200 baud.
  localparam int UART_DEFAULT_DIVISOR      = 50_000_000 / 115_200;
  localparam int UART_DEFAULT_COUNTER_SIZE = 9;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } uart_state_e;

  // Parity over up to 8 data bits; narrower words are zero-extended,
  // which leaves the XOR unchanged.
  function automatic logic calc_parity(input logic [7:0] data, input logic odd);
    return (^data) ^ odd;
  endfunction

endpackage

// File: rtl/uart_tx_baud_cnt.sv
// Bit-period counter for the transmitter. Unlike the receiver's
// free-running divider it is held at zero while restart is high, so the
// first bit of a frame always lasts a full DIVISOR clocks.
module uart_tx_baud_cnt
  import uart_pkg::*;
#(
  parameter int COUNTER_SIZE = UART_DEFAULT_COUNTER_SIZE,
  parameter int DIVISOR      = UART_DEFAULT_DIVISOR
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_restart,
  input  logic i_enable,
  output logic o_bit_end
);

  localparam logic [COUNTER_SIZE-1:0] LAST_COUNT = COUNTER_SIZE'(DIVISOR - 1);

  logic [COUNTER_SIZE-1:0] cnt_reg;
  logic [COUNTER_SIZE-1:0] cnt_next;

  assign o_bit_end = i_enable && !i_restart && (cnt_reg == LAST_COUNT);

  // Next count: clear on restart or at the bit boundary, else advance.
  always_comb begin
    cnt_next = cnt_reg;
    if (i_restart) begin
      cnt_next = '0;
    end else if (i_enable) begin
      cnt_next = o_bit_end ? '0 : cnt_reg + COUNTER_SIZE'(1);
    end
  end

  // Counter register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cnt_reg <= '0;
    end else begin
      cnt_reg <= cnt_next;
    end
  end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: one byte per valid/ready handshake, sent as start,
// data (LSB first), optional parity and 1 or 2 stop bits. The line is
// driven straight from a flop so it never glitches.
module uart_tx
  import uart_pkg::*;
#(
  parameter int COUNTER_SIZE = UART_DEFAULT_COUNTER_SIZE,
  parameter int DIVISOR      = UART_DEFAULT_DIVISOR,
  parameter int DATA_BITS    = 8,
  parameter int PARITY_EN    = 0,
  parameter int PARITY_ODD   = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic [DATA_BITS-1:0] i_data,
  input  logic                 i_valid,
  output logic                 o_ready,
  output logic                 o_txd,
  output logic                 o_busy,
  output logic                 o_done
);

  if (DIVISOR < 2 || DIVISOR >= (1 << COUNTER_SIZE)) begin : g_bad_divisor
    $error("uart_tx: DIVISOR must be 2..2**COUNTER_SIZE-1");
  end
  if (DATA_BITS < 5 || DATA_BITS > 8) begin : g_bad_data_bits
    $error("uart_tx: DATA_BITS must be 5..8");
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop_bits
    $error("uart_tx: STOP_BITS must be 1 or 2");
  end

  localparam logic [2:0] LAST_BIT  = 3'(DATA_BITS - 1);
  localparam logic       LAST_STOP = 1'(STOP_BITS - 1);

  uart_state_e          state_reg, state_next;
  logic [DATA_BITS-1:0] shift_reg, shift_next;
  logic [2:0]           bit_idx_reg, bit_idx_next;
  logic                 stop_idx_reg, stop_idx_next;
  logic                 parity_reg, parity_next;
  logic                 txd_reg, txd_next;
  logic                 done_reg, done_next;
  logic                 bit_end;

  // The counter is parked at zero whenever no frame is running.
  uart_tx_baud_cnt #(
    .COUNTER_SIZE (COUNTER_SIZE),
    .DIVISOR      (DIVISOR)
  ) u_baud_cnt (
    .i_clk     (i_clk),
    .i_rst_n   (i_rst_n),
    .i_restart (state_reg == ST_IDLE),
    .i_enable  (state_reg != ST_IDLE),
    .o_bit_end (bit_end)
  );

  assign o_ready = (state_reg == ST_IDLE);
  assign o_busy  = (state_reg != ST_IDLE);
  assign o_txd   = txd_reg;
  assign o_done  = done_reg;

  // Frame sequencing; txd_next is the line level for the coming bit.
  always_comb begin
    state_next    = state_reg;
    shift_next    = shift_reg;
    bit_idx_next  = bit_idx_reg;
    stop_idx_next = stop_idx_reg;
    parity_next   = parity_reg;
    txd_next      = txd_reg;
    done_next     = 1'b0;
    unique case (state_reg)
      ST_IDLE: begin
        txd_next = 1'b1;
        if (i_valid) begin
          state_next    = ST_START;
          shift_next    = i_data;
          parity_next   = calc_parity(8'(i_data), PARITY_ODD != 0);
          bit_idx_next  = '0;
          stop_idx_next = 1'b0;
          txd_next      = 1'b0;
        end
      end
      ST_START: begin
        if (bit_end) begin
          state_next = ST_DATA;
          txd_next   = shift_reg[0];
        end
      end
      ST_DATA: begin
        if (bit_end) begin
          shift_next = shift_reg >> 1;
          if (bit_idx_reg == LAST_BIT) begin
            if (PARITY_EN != 0) begin
              state_next = ST_PARITY;
              txd_next   = parity_reg;
            end else begin
              state_next = ST_STOP;
              txd_next   = 1'b1;
            end
          end else begin
            bit_idx_next = bit_idx_reg + 3'd1;
            txd_next     = shift_reg[1];
          end
        end
      end
      ST_PARITY: begin
        if (bit_end) begin
          state_next = ST_STOP;
          txd_next   = 1'b1;
        end
      end
      ST_STOP: begin
        txd_next = 1'b1;
        if (bit_end) begin
          if (stop_idx_reg == LAST_STOP) begin
            state_next = ST_IDLE;
            done_next  = 1'b1;
          end else begin
            stop_idx_next = 1'b1;
          end
        end
      end
      default: begin
        state_next = ST_IDLE;
        txd_next   = 1'b1;
      end
    endcase
  end

  // State and datapath registers; reset abandons any frame in flight.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_reg    <= ST_IDLE;
      shift_reg    <= '0;
      bit_idx_reg  <= '0;
      stop_idx_reg <= 1'b0;
      parity_reg   <= 1'b0;
      txd_reg      <= 1'b1;
      done_reg     <= 1'b0;
    end else begin
      state_reg    <= state_next;
      shift_reg    <= shift_next;
      bit_idx_reg  <= bit_idx_next;
      stop_idx_reg <= stop_idx_next;
      parity_reg   <= parity_next;
      txd_reg      <= txd_next;
      done_reg     <= done_next;
    end
  end

endmodule
